// File: rtl/sam_pkg.sv
// Shared types and constants for the SAM hardwired sequencer: state encoding,
// control-word bit positions, opcodes and the per-state control words.
package sam_pkg;

  typedef enum logic [3:0] {
    S_RST  = 4'd0,
    S_F0   = 4'd1,
    S_F1   = 4'd2,
    S_F2   = 4'd3,
    S_F3   = 4'd4,
    S_DEC  = 4'd5,
    S_A0   = 4'd6,
    S_R1   = 4'd7,
    S_R2   = 4'd8,
    S_LD   = 4'd9,
    S_AD   = 4'd10,
    S_W0   = 4'd11,
    S_W1   = 4'd12,
    S_W2   = 4'd13,
    S_BR   = 4'd14,
    S_HALT = 4'd15
  } state_t;

  localparam int B_RBUS_ALU   = 0;
  localparam int B_RBUS_AC    = 1;
  localparam int B_REQUEST    = 2;
  localparam int B_RW         = 3;
  localparam int B_PC_ABUS    = 4;
  localparam int B_PC_INC     = 5;
  localparam int B_PC_CLR     = 6;
  localparam int B_MBUS_MBR   = 7;
  localparam int B_MBR_RBUS   = 8;
  localparam int B_MBR_DATA   = 9;
  localparam int B_MAR_ABUS   = 10;
  localparam int B_IR_ABUS    = 11;
  localparam int B_DATA_MBR   = 12;
  localparam int B_ADDR_MAR   = 13;
  localparam int B_ALU_PASS_B = 14;
  localparam int B_ALU_ADD    = 15;
  localparam int B_ALU_B_MBUS = 16;
  localparam int B_ALU_A_AC   = 17;
  localparam int B_AC_RBUS    = 18;
  localparam int B_ABUS_MBR   = 19;
  localparam int B_ABUS_IR    = 20;
  localparam int B_ABUS_PC    = 21;

  localparam logic [1:0] OP_LOAD  = 2'b00;
  localparam logic [1:0] OP_STORE = 2'b01;
  localparam logic [1:0] OP_ADD   = 2'b10;
  localparam logic [1:0] OP_BRN   = 2'b11;

  localparam logic [21:0] CW_NONE = 22'h000000;
  localparam logic [21:0] CW_RST  = (22'd1 << B_PC_CLR);
  localparam logic [21:0] CW_F0   = (22'd1 << B_ABUS_PC) | (22'd1 << B_MAR_ABUS);
  localparam logic [21:0] CW_RD   = (22'd1 << B_ADDR_MAR) | (22'd1 << B_RW) | (22'd1 << B_REQUEST);
  localparam logic [21:0] CW_RDW  = CW_RD | (22'd1 << B_MBR_DATA);
  localparam logic [21:0] CW_F3   = (22'd1 << B_ABUS_MBR) | (22'd1 << B_IR_ABUS) | (22'd1 << B_PC_INC);
  localparam logic [21:0] CW_A0   = (22'd1 << B_ABUS_IR) | (22'd1 << B_MAR_ABUS);
  localparam logic [21:0] CW_LD   = (22'd1 << B_MBUS_MBR) | (22'd1 << B_ALU_B_MBUS) | (22'd1 << B_ALU_PASS_B)
                                  | (22'd1 << B_RBUS_ALU) | (22'd1 << B_AC_RBUS);
  localparam logic [21:0] CW_AD   = (22'd1 << B_MBUS_MBR) | (22'd1 << B_ALU_B_MBUS) | (22'd1 << B_ALU_A_AC)
                                  | (22'd1 << B_ALU_ADD) | (22'd1 << B_RBUS_ALU) | (22'd1 << B_AC_RBUS);
  localparam logic [21:0] CW_W0   = (22'd1 << B_RBUS_AC) | (22'd1 << B_MBR_RBUS);
  localparam logic [21:0] CW_WR   = (22'd1 << B_ADDR_MAR) | (22'd1 << B_DATA_MBR) | (22'd1 << B_REQUEST);
  localparam logic [21:0] CW_BR   = (22'd1 << B_ABUS_IR) | (22'd1 << B_PC_ABUS);

  // Control word driven while sitting in state s; BR only loads PC when AC is negative.
  function automatic logic [21:0] cw_of(state_t s, logic ac15);
    logic [21:0] cw;
    case (s)
      S_RST:   cw = CW_RST;
      S_F0:    cw = CW_F0;
      S_F1:    cw = CW_RD;
      S_F2:    cw = CW_RDW;
      S_F3:    cw = CW_F3;
      S_A0:    cw = CW_A0;
      S_R1:    cw = CW_RD;
      S_R2:    cw = CW_RDW;
      S_LD:    cw = CW_LD;
      S_AD:    cw = CW_AD;
      S_W0:    cw = CW_W0;
      S_W1:    cw = CW_WR;
      S_W2:    cw = CW_WR;
      S_BR:    cw = ac15 ? CW_BR : CW_NONE;
      default: cw = CW_NONE;
    endcase
    return cw;
  endfunction

  function automatic logic is_wait_state(state_t s);
    return (s == S_F2) || (s == S_R2) || (s == S_W2);
  endfunction

endpackage

// File: rtl/sam_wait_timer.sv
// Consecutive wait-cycle counter for one memory access; flags the cycle on
// which the WAIT_MAX-th wait cycle is seen. Used only with SAM_WAIT_TIMEOUT_EN.
module sam_wait_timer #(
  parameter int WAIT_MAX = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic active,
  input  logic wait_i,
  output logic expired
);

  localparam int CW = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX + 1);

  logic [CW-1:0] count_r;

  assign expired = active && wait_i && (count_r == CW'(WAIT_MAX - 1));

  // Counter is held at zero outside wait states, so it is clear on every entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r <= '0;
    end else if (!active) begin
      count_r <= '0;
    end else if (wait_i && !expired) begin
      count_r <= count_r + CW'(1);
    end else begin
      count_r <= count_r;
    end
  end

endmodule

// File: rtl/sam_seq_fsm.sv
// SAM hardwired sequencer: fetch/decode/execute FSM with registered control word.
// Optional wait-timeout to HALT is enabled by defining SAM_WAIT_TIMEOUT_EN.
module sam_seq_fsm
  import sam_pkg::*;
#(
  parameter int WAIT_MAX = 255,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wait_i,
  input  logic             ir15,
  input  logic             ir14,
  input  logic             ac15,
  output logic [21:0]      b,
  output logic [3:0]       state_o,
  output logic [CNT_W-1:0] instr_cnt,
  output logic             err_o
);

  state_t           state_r;
  state_t           next_s;
  logic [21:0]      b_r;
  logic [CNT_W-1:0] cnt_r;
  logic [1:0]       op_r;
  logic [1:0]       ir_op_s;
  logic             retire_s;
  logic             timeout_s;

  assign ir_op_s   = {ir15, ir14};
  assign b         = b_r;
  assign state_o   = state_r;
  assign instr_cnt = cnt_r;

`ifdef SAM_WAIT_TIMEOUT_EN
  logic err_r;

  sam_wait_timer #(.WAIT_MAX(WAIT_MAX)) u_wait_timer (
    .clk     (clk),
    .rst     (rst),
    .active  (is_wait_state(state_r)),
    .wait_i  (wait_i),
    .expired (timeout_s)
  );

  assign err_o = err_r;

  // Error flag latches on entry to HALT and only reset clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_r <= 1'b0;
    end else begin
      err_r <= (next_s == S_HALT);
    end
  end
`else
  assign timeout_s = 1'b0;
  assign err_o     = 1'b0;
`endif

  // Next-state rule and the retire strobe for the instruction counter.
  always_comb begin
    next_s   = state_r;
    retire_s = 1'b0;
    case (state_r)
      S_RST: next_s = S_F0;
      S_F0:  next_s = S_F1;
      S_F1:  next_s = S_F2;
      S_F2: begin
        if (timeout_s)    next_s = S_HALT;
        else if (!wait_i) next_s = S_F3;
        else              next_s = S_F2;
      end
      S_F3:  next_s = S_DEC;
      S_DEC: next_s = (ir_op_s == OP_BRN) ? S_BR : S_A0;
      S_A0:  next_s = (ir_op_s == OP_STORE) ? S_W0 : S_R1;
      S_R1:  next_s = S_R2;
      S_R2: begin
        if (timeout_s)    next_s = S_HALT;
        else if (!wait_i) next_s = (op_r == OP_ADD) ? S_AD : S_LD;
        else              next_s = S_R2;
      end
      S_LD, S_AD, S_BR: begin
        next_s   = S_F0;
        retire_s = 1'b1;
      end
      S_W0:  next_s = S_W1;
      S_W1:  next_s = S_W2;
      S_W2: begin
        if (timeout_s) begin
          next_s = S_HALT;
        end else if (!wait_i) begin
          next_s   = S_F0;
          retire_s = 1'b1;
        end else begin
          next_s = S_W2;
        end
      end
      S_HALT:  next_s = S_HALT;
      default: next_s = S_RST;
    endcase
  end

  // State, control word, opcode latch and retired-instruction counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= S_RST;
      b_r     <= CW_RST;
      cnt_r   <= '0;
      op_r    <= OP_LOAD;
    end else begin
      state_r <= next_s;
      b_r     <= cw_of(next_s, ac15);
      if (retire_s) begin
        cnt_r <= cnt_r + CNT_W'(1);
      end else begin
        cnt_r <= cnt_r;
      end
      // Opcode is captured when leaving DEC and A0 so R2 can pick LD vs AD.
      if ((state_r == S_DEC) || (state_r == S_A0)) begin
        op_r <= ir_op_s;
      end else begin
        op_r <= op_r;
      end
    end
  end

endmodule

// File: tb/tb_sam_seq_fsm.sv
// Self-checking bench for sam_seq_fsm: literal vector table, directed sequences
// and randomized instructions checked against a per-instruction step model.
module tb_sam_seq_fsm;
  import sam_pkg::*;

  localparam int CNT_W = 16;

  localparam logic [21:0] E_RST = 22'h000040;
  localparam logic [21:0] E_F0  = 22'h200400;
  localparam logic [21:0] E_RD  = 22'h00200C;
  localparam logic [21:0] E_RDW = 22'h00220C;
  localparam logic [21:0] E_F3  = 22'h080820;
  localparam logic [21:0] E_A0  = 22'h100400;
  localparam logic [21:0] E_LD  = 22'h054081;
  localparam logic [21:0] E_AD  = 22'h078081;
  localparam logic [21:0] E_W0  = 22'h000102;
  localparam logic [21:0] E_WR  = 22'h003004;
  localparam logic [21:0] E_BRT = 22'h100010;

  logic             clk = 1'b0;
  logic             rst;
  logic             wait_i;
  logic             ir15;
  logic             ir14;
  logic             ac15;
  logic [21:0]      b;
  logic [3:0]       state_o;
  logic [CNT_W-1:0] instr_cnt;
  logic             err_o;

  int errors  = 0;
  int checks  = 0;
  int retired = 0;

  typedef struct {
    logic             w;
    logic [1:0]       ir;
    logic             ac;
    state_t           st;
    logic [21:0]      bw;
    logic [CNT_W-1:0] cnt;
    logic             err;
  } vec_t;

  vec_t q[$];
  vec_t tbl[18];

  sam_seq_fsm #(.WAIT_MAX(4), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .wait_i    (wait_i),
    .ir15      (ir15),
    .ir14      (ir14),
    .ac15      (ac15),
    .b         (b),
    .state_o   (state_o),
    .instr_cnt (instr_cnt),
    .err_o     (err_o)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic rb();
    return 1'($urandom);
  endfunction

  function automatic logic [1:0] rop();
    return 2'($urandom);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare current outputs to v, then drive v's inputs across one posedge.
  task automatic apply(input vec_t v);
    check("state", 32'(state_o), 32'(v.st));
    check("b", 32'(b), 32'(v.bw));
    check("instr_cnt", 32'(instr_cnt), 32'(v.cnt));
    check("err_o", 32'(err_o), 32'(v.err));
    wait_i = v.w;
    {ir15, ir14} = v.ir;
    ac15 = v.ac;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input state_t st, input logic [21:0] bw, input logic w,
                      input logic [1:0] ir, input logic ac);
    vec_t v;
    v.w = w; v.ir = ir; v.ac = ac; v.st = st; v.bw = bw;
    v.cnt = CNT_W'(retired); v.err = 1'b0;
    q.push_back(v);
  endtask

  // Expected step list for one instruction: fetch with wf wait cycles, then
  // execute with wd wait cycles. ir/ac only matter where they are decoded.
  task automatic plan_instr(input logic [1:0] op, input int wf, input int wd, input logic ac);
    push(S_F0, E_F0, rb(), rop(), rb());
    push(S_F1, E_RD, rb(), rop(), rb());
    for (int i = 0; i < wf; i++) push(S_F2, E_RDW, 1'b1, rop(), rb());
    push(S_F2, E_RDW, 1'b0, rop(), rb());
    push(S_F3, E_F3, rb(), rop(), rb());
    push(S_DEC, 22'h0, rb(), op, ac);
    if (op == 2'b11) begin
      push(S_BR, ac ? E_BRT : 22'h0, rb(), rop(), ac);
    end else begin
      push(S_A0, E_A0, rb(), op, rb());
      if (op == 2'b01) begin
        push(S_W0, E_W0, rb(), rop(), rb());
        push(S_W1, E_WR, rb(), rop(), rb());
        for (int i = 0; i < wd; i++) push(S_W2, E_WR, 1'b1, rop(), rb());
        push(S_W2, E_WR, 1'b0, rop(), rb());
      end else begin
        push(S_R1, E_RD, rb(), rop(), rb());
        for (int i = 0; i < wd; i++) push(S_R2, E_RDW, 1'b1, rop(), rb());
        push(S_R2, E_RDW, 1'b0, rop(), rb());
        push((op == 2'b10) ? S_AD : S_LD, (op == 2'b10) ? E_AD : E_LD, rb(), rop(), rb());
      end
    end
    retired++;
  endtask

  task automatic drain();
    vec_t v;
    while (q.size() > 0) begin
      v = q.pop_front();
      apply(v);
    end
  endtask

  initial begin
    tbl[0]  = '{1'b0, 2'b01, 1'b0, S_RST, 22'h000040, 16'd0, 1'b0};
    tbl[1]  = '{1'b1, 2'b10, 1'b1, S_F0,  22'h200400, 16'd0, 1'b0};
    tbl[2]  = '{1'b1, 2'b11, 1'b0, S_F1,  22'h00200C, 16'd0, 1'b0};
    tbl[3]  = '{1'b0, 2'b00, 1'b1, S_F2,  22'h00220C, 16'd0, 1'b0};
    tbl[4]  = '{1'b1, 2'b10, 1'b0, S_F3,  22'h080820, 16'd0, 1'b0};
    tbl[5]  = '{1'b1, 2'b01, 1'b0, S_DEC, 22'h000000, 16'd0, 1'b0};
    tbl[6]  = '{1'b0, 2'b01, 1'b1, S_A0,  22'h100400, 16'd0, 1'b0};
    tbl[7]  = '{1'b1, 2'b10, 1'b0, S_W0,  22'h000102, 16'd0, 1'b0};
    tbl[8]  = '{1'b1, 2'b00, 1'b1, S_W1,  22'h003004, 16'd0, 1'b0};
    tbl[9]  = '{1'b1, 2'b11, 1'b0, S_W2,  22'h003004, 16'd0, 1'b0};
    tbl[10] = '{1'b0, 2'b10, 1'b1, S_W2,  22'h003004, 16'd0, 1'b0};
    tbl[11] = '{1'b0, 2'b00, 1'b0, S_F0,  22'h200400, 16'd1, 1'b0};
    tbl[12] = '{1'b0, 2'b01, 1'b1, S_F1,  22'h00200C, 16'd1, 1'b0};
    tbl[13] = '{1'b1, 2'b00, 1'b0, S_F2,  22'h00220C, 16'd1, 1'b0};
    tbl[14] = '{1'b0, 2'b10, 1'b0, S_F2,  22'h00220C, 16'd1, 1'b0};
    tbl[15] = '{1'b0, 2'b01, 1'b1, S_F3,  22'h080820, 16'd1, 1'b0};
    tbl[16] = '{1'b0, 2'b11, 1'b1, S_DEC, 22'h000000, 16'd1, 1'b0};
    tbl[17] = '{1'b1, 2'b00, 1'b1, S_BR,  22'h100010, 16'd1, 1'b0};

    rst = 1'b1; wait_i = 1'b0; ir15 = 1'b0; ir14 = 1'b0; ac15 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", 32'(state_o), 32'(S_RST));
    check("reset_b", 32'(b), 32'h000040);
    check("reset_cnt", 32'(instr_cnt), 32'h0);
    check("reset_err", 32'(err_o), 32'h0);
    rst = 1'b0;

    // STORE with one W2 wait, then BRN taken.
    for (int i = 0; i < 18; i++) apply(tbl[i]);
    retired = 2;

    // LOAD with 3 R2 waits, ADD, BRN not taken, STORE with waits.
    plan_instr(OP_LOAD, 0, 3, 1'b1);
    plan_instr(OP_ADD, 1, 0, 1'b0);
    plan_instr(OP_BRN, 0, 0, 1'b0);
    plan_instr(OP_STORE, 2, 1, 1'b1);
    drain();

    for (int n = 0; n < 40; n++) begin
      plan_instr(rop(), int'($urandom_range(3, 0)), int'($urandom_range(3, 0)), rb());
      drain();
    end

    // Reset asserted between edges while R2 is waiting.
    wait_i = 1'b0; {ir15, ir14} = OP_LOAD;
    for (int i = 0; i < 20 && state_o !== S_R2; i++) begin
      @(posedge clk);
      #1;
    end
    check("reach_r2", 32'(state_o), 32'(S_R2));
    wait_i = 1'b1;
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_state", 32'(state_o), 32'(S_RST));
    check("async_rst_b", 32'(b), 32'h000040);
    check("async_rst_cnt", 32'(instr_cnt), 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    wait_i = 1'b0;
    retired = 0;
    push(S_RST, E_RST, rb(), rop(), rb());
    plan_instr(OP_LOAD, 0, 0, 1'b0);
    plan_instr(OP_ADD, 1, 2, 1'b0);
    drain();

`ifdef SAM_WAIT_TIMEOUT_EN
    // Wait stuck high in F2: four wait cycles then HALT until reset.
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    retired = 0;
    push(S_RST, E_RST, 1'b1, 2'b00, 1'b0);
    push(S_F0, E_F0, 1'b1, 2'b00, 1'b0);
    push(S_F1, E_RD, 1'b1, 2'b00, 1'b0);
    for (int i = 0; i < 4; i++) push(S_F2, E_RDW, 1'b1, 2'b00, 1'b0);
    for (int i = 0; i < 3; i++) begin
      push(S_HALT, 22'h0, 1'b0, 2'b00, 1'b0);
      q[q.size() - 1].err = 1'b1;
    end
    drain();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
